// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the nibble-serial adder
package add_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/adder_slice4.sv
// adder_slice4: combinational 4-bit ripple-carry slice
module adder_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] out,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign out[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: nibble-serial adder with valid/ready handshakes; ADD_SEQ_OVF_EN adds signed-overflow output ovf
module add_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  import add_seq_pkg::*;
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW = $clog2(NIB);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic c_q, c_d, cout_q, cout_d, out_valid_q, out_valid_d;
  logic [NIBBLE_W-1:0] s_out;
  logic s_cout, last;
  adder_slice4 u_slice (
    .a   (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b   (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .cin (c_q),
    .out (s_out),
    .cout(s_cout)
  );
  assign last = idx_q == IW'(NIB - 1);
  assign in_ready = (state_q == IDLE) && !rst;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        idx_d   = '0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = s_out;
        c_d   = s_cout;
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          cout_d  = s_cout;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef ADD_SEQ_OVF_EN
  // overflow when operand signs agree but the final sum bit disagrees
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_out[NIBBLE_W-1] != a_q[WIDTH-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed self-checking bench for add_seq_ctrl (WIDTH=16)
module tb_add_seq_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin = 0;
  logic in_ready, out_valid, cout;
  logic [15:0] a = 0, b = 0, sum;
  int total = 0, bad = 0;
`ifdef ADD_SEQ_OVF_EN
  logic ovf;
`endif
  add_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  // accept one operand set, then step negedges until out_valid (bounded)
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci, output int n);
    @(negedge clk);
    a = ai; b = bi; cin = ci; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic handshake;
    @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 0 || out_valid !== 0) begin bad++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
    total++; if (sum !== 16'h0 || cout !== 0) begin bad++; $display("FAIL reset_data: sum=%h cout=%b want 0000 0", sum, cout); end
    rst = 0;
    @(negedge clk);
    total++; if (in_ready !== 1) begin bad++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
  endtask
  task automatic test_basic;
    int n;
    run_op(16'h1234, 16'h4321, 0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", n); end
    total++; if (sum !== 16'h5555 || cout !== 0) begin bad++; $display("FAIL basic_sum: sum=%h cout=%b want 5555 0", sum, cout); end
    handshake();
    total++; if (in_ready !== 1 || out_valid !== 0) begin bad++; $display("FAIL basic_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_carry;
    int n;
    run_op(16'hFFFF, 16'h0001, 0, n);
    total++; if (sum !== 16'h0000 || cout !== 1 || n !== 4) begin bad++; $display("FAIL carry_ripple: sum=%h cout=%b lat=%0d want 0000 1 4", sum, cout, n); end
    handshake();
    run_op(16'hFFFF, 16'h0000, 1, n);
    total++; if (sum !== 16'h0000 || cout !== 1 || n !== 4) begin bad++; $display("FAIL carry_cin: sum=%h cout=%b lat=%0d want 0000 1 4", sum, cout, n); end
    handshake();
  endtask
  task automatic test_backpressure;
    int n;
    run_op(16'h0F0F, 16'h0101, 1, n);
    total++; if (sum !== 16'h1011 || cout !== 0) begin bad++; $display("FAIL bp_sum: sum=%h cout=%b want 1011 0", sum, cout); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 16'hAAAA; b = 16'h5555; cin = 1;
      @(negedge clk);
      total++; if (out_valid !== 1 || in_ready !== 0 || sum !== 16'h1011 || cout !== 0) begin bad++; $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 1011 0", i, out_valid, in_ready, sum, cout); end
    end
    in_valid = 0;
    handshake();
    total++; if (in_ready !== 1 || out_valid !== 0) begin bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_abort;
    int n;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++; if (out_valid !== 0 || sum !== 0 || cout !== 0 || in_ready !== 0) begin bad++; $display("FAIL abort_state: out_valid=%b sum=%h cout=%b in_ready=%b want 0 0000 0 0", out_valid, sum, cout, in_ready); end
    rst = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 0) n++;
    end
    total++; if (n !== 0 || in_ready !== 1) begin bad++; $display("FAIL abort_no_valid: valid_cycles=%0d in_ready=%b want 0 1", n, in_ready); end
    run_op(16'h0001, 16'h0001, 0, n);
    total++; if (sum !== 16'h0002 || cout !== 0 || n !== 4) begin bad++; $display("FAIL abort_next: sum=%h cout=%b lat=%0d want 0002 0 4", sum, cout, n); end
    handshake();
  endtask
  task automatic test_change;
    int n;
    @(negedge clk);
    a = 16'h0A5C; b = 16'h1234; cin = 1; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      a = 16'hFFFF - 16'(n); b = 16'hF0F0; cin = n[0];
      @(negedge clk);
      n++;
    end
    total++; if (n !== 4 || sum !== 16'h1C91 || cout !== 0) begin bad++; $display("FAIL change_latched: sum=%h cout=%b lat=%0d want 1c91 0 4", sum, cout, n); end
    @(negedge clk);
    out_ready = 0;
    total++; if (out_valid !== 0 || in_ready !== 1) begin bad++; $display("FAIL change_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask
`ifdef ADD_SEQ_OVF_EN
  task automatic test_ovf;
    int n;
    run_op(16'h7FFF, 16'h0001, 0, n);
    total++; if (sum !== 16'h8000 || ovf !== 1 || cout !== 0) begin bad++; $display("FAIL ovf_pos: sum=%h ovf=%b cout=%b want 8000 1 0", sum, ovf, cout); end
    handshake();
    run_op(16'h8000, 16'h8000, 0, n);
    total++; if (sum !== 16'h0000 || ovf !== 1 || cout !== 1) begin bad++; $display("FAIL ovf_neg: sum=%h ovf=%b cout=%b want 0000 1 1", sum, ovf, cout); end
    handshake();
    run_op(16'h1234, 16'h4321, 0, n);
    total++; if (sum !== 16'h5555 || ovf !== 0) begin bad++; $display("FAIL ovf_none: sum=%h ovf=%b want 5555 0", sum, ovf); end
    handshake();
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_abort();
    test_change();
`ifdef ADD_SEQ_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
